fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

- Shares the write port of one 8-bit FIFO among `N` producers using round-robin arbitration with bounded bursts.
- Tracks FIFO occupancy by counting its own issued writes and the consumer's reads, so a write is never issued into a full FIFO.
- Sits between the producer blocks and the FIFO's `yazma_cs`/`data_in` pins.
- Observes the FIFO's `okuma_cs`, `ready` and `overflow`.

## Interface
Parameters:
- `N`, 4: number of producers (2..8).
- `DEPTH`, 8: FIFO buffer depth. Usable capacity is `DEPTH-1`.
- `BURST`, 4: maximum consecutive grants to one producer (1..15).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-producer write request; must hold with stable data until acked.
- `req_data`  in  8*N  producer data, producer `i` at bits `[8i+7:8i]`.
- `ack`  out  N  combinational one-hot grant. Data is captured at the edge where `req[i] & ack[i]`.
- `fifo_yazma_cs`  out  1  registered write strobe to the FIFO.
- `fifo_data`  out  8  registered write data to the FIFO.
- `fifo_okuma_cs`  in  1  consumer read strobe, tapped from the FIFO read port.
- `fifo_ready`  in  1  FIFO non-empty flag.
- `fifo_overflow`  in  1  FIFO overflow flag.
- `level`  out  log2(DEPTH)+1  occupancy count, including any in-flight write.
- `full`  out  1  `level == DEPTH-1`.
- `err`  out  1  sticky; set when `fifo_overflow` is seen high. Cleared only by reset.

## Operation
Signals:
- `rd_obs = fifo_okuma_cs & fifo_ready`.
- `space = (level < DEPTH-1)`.
- A grant is issued only when `space` is true. A read in the same cycle does not create space; this is conservative, by design.
- `level_next = level + issue - rd_obs`. Both terms may occur in one cycle, giving a net change of 0.
- `level` never exceeds `DEPTH-1` and never underflows.

Winner selection (combinational, at most one `ack` bit set):
- In BURST with `req[owner]` high, `beat < BURST` and `space`: the winner is `owner`.
- Otherwise: the first requester with `req` high, scanning from `rr_ptr` upward modulo `N`, provided `space` is true.

State machine (`state`, `owner`, `beat` in 4 bits, `rr_ptr`):
- **IDLE**: on a grant to `w`, go to BURST with `owner=w` and `beat=1`.
- **BURST**, owner re-granted: increment `beat`.
  - If `beat` reaches `BURST` on this grant, set `rr_ptr = owner+1 mod N` and go to IDLE.
- **BURST**, owner drops `req` or `space` is false: set `rr_ptr = owner+1 mod N`.
  - If another requester wins in this same cycle, it becomes owner with `beat=1`.
  - Otherwise go to IDLE.

Issue (on the edge where a grant occurs):
- `fifo_yazma_cs <= 1`.
- `fifo_data <= req_data[winner]`.

Otherwise `fifo_yazma_cs <= 0` and `fifo_data` holds its value.

## Timing
- Reset (async, `rst` low): outputs and state take these values immediately and hold until the first rising edge after `rst` goes high.
  - `fifo_yazma_cs=0`, `fifo_data=0`, `level=0`, `full=0`, `err=0`.
  - `state=IDLE`, `rr_ptr=0`, `beat=0`.
  - `ack=0`, since the grant logic is gated by reset.
- Latency:
  - `req` high in cycle `t` with space gives `ack` in cycle `t`.
  - `fifo_yazma_cs` is high in `t+1`.
  - The FIFO stores the word at the end of `t+1`.
- Throughput: one write per cycle sustained.
- `level` increments at the edge ending cycle `t`. `full` is a registered compare of `level`.
- `err` sets at the edge after `fifo_overflow` is sampled high.
- A mid-burst reset discards the in-flight write. `level` returns to 0; the FIFO is reset by the same `rst`.
- `req` lowered before its `ack` is a legal withdrawal; no data is captured.

## Test plan
- **Reset:** assert `rst=0` mid-stream with `req=4'b1111`.
  - Required: `ack=0`, `fifo_yazma_cs=0`, `level=0` without waiting for a clock edge.
  - Required after release: the first grant goes to producer 0.
- **Round-robin:** `BURST=1`, all four producers hold `req`, consumer reads every cycle.
  - Required: `ack` sequence 1,2,4,8,1,… with `fifo_data` matching each producer's tag (`0xA0+i`).
- **Burst:** `BURST=4`, producers 1 and 2 hold `req`, consumer reads every cycle.
  - Required: producer 1 gets 4 consecutive acks, then producer 2 gets 4, then it alternates.
  - Required: `beat` never exceeds 4.
- **Full:** no reads, producer 0 requests continuously.
  - Required: exactly 7 acks, `level=7`, `full=1`, then `ack=0`.
  - Required: one `fifo_okuma_cs` pulse with `fifo_ready=1` lowers `level` to 6 and the next cycle grants again.
- **Simultaneous read and write:** with `level=3`, a grant and a read occur in the same cycle.
  - Required: `level` stays 3.
  - Required: with `level=0` and `fifo_okuma_cs=1`, `fifo_ready=0`, `level` stays 0.
- **Error and withdrawal:** force `fifo_overflow=1` for one cycle, and have producer 3 drop `req` before it is granted.
  - Required: `err=1` from the next edge and sticky until reset.
  - Required: no capture for producer 3 and `level` unchanged by it.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Bundle of producer handshake, FIFO write-port and status signals for
// fifo_write_arbiter. The arbiter uses the slave view; the environment that
// drives the producers and observes the FIFO uses the master view.
interface fifo_write_arbiter_if #(
  parameter int N     = 4,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic           fifo_yazma_cs;
  logic [7:0]     fifo_data;
  logic           fifo_okuma_cs;
  logic           fifo_ready;
  logic           fifo_overflow;
  logic [LW-1:0]  level;
  logic           full;
  logic           err;

  modport master (
    output req, req_data, fifo_okuma_cs, fifo_ready, fifo_overflow,
    input  ack, fifo_yazma_cs, fifo_data, level, full, err
  );

  modport slave (
    input  req, req_data, fifo_okuma_cs, fifo_ready, fifo_overflow,
    output ack, fifo_yazma_cs, fifo_data, level, full, err
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for a shared 8-bit FIFO. Grants one producer
// per cycle, lets an owner keep the port for up to BURST consecutive beats,
// and keeps its own occupancy count so the FIFO is never written when full.
module fifo_write_arbiter #(
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int BURST = 4
) (
  input logic                 clk,
  input logic                 rst,
  fifo_write_arbiter_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t         state_q;
  logic [PW-1:0]  owner_q;
  logic [PW-1:0]  rr_q;
  logic [3:0]     beat_q;
  logic [LW-1:0]  level_q;
  logic [LW-1:0]  level_d;
  logic           full_q;
  logic           err_q;
  logic           wr_q;
  logic [7:0]     data_q;

  logic           rd_obs_s;
  logic           space_s;
  logic           hold_s;
  logic           grant_s;
  logic [PW-1:0]  win_s;
  logic [PW-1:0]  base_s;
  logic [N-1:0]   ack_s;

  // Successor of a producer index, wrapping at N.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    logic [PW-1:0] r;
    if (i == PW'(N - 1)) begin
      r = {PW{1'b0}};
    end else begin
      r = i + PW'(1);
    end
    return r;
  endfunction

  // Producer index k positions above base, modulo N.
  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return PW'(s);
  endfunction

  // Winner selection: the burst owner keeps the port while it requests and has
  // beats left; otherwise scan upward from the pointer. Reset gates every grant.
  always_comb begin
    rd_obs_s = bus.fifo_okuma_cs & bus.fifo_ready;
    // A read in this cycle is deliberately not counted as new space.
    space_s  = (level_q < LW'(DEPTH - 1));
    hold_s   = (state_q == ST_BURST) && bus.req[owner_q] &&
               (beat_q < 4'(BURST)) && space_s;
    // When a burst is interrupted the scan already starts past the old owner.
    base_s   = (state_q == ST_BURST) ? next_idx(owner_q) : rr_q;
    grant_s  = 1'b0;
    win_s    = {PW{1'b0}};
    if (!rst) begin
      grant_s = 1'b0;
    end else if (!space_s) begin
      grant_s = 1'b0;
    end else if (hold_s) begin
      grant_s = 1'b1;
      win_s   = owner_q;
    end else begin
      // Scan downward so the requester closest to base is assigned last.
      for (int k = N - 1; k >= 0; k--) begin
        if (bus.req[rot_idx(base_s, k)]) begin
          grant_s = 1'b1;
          win_s   = rot_idx(base_s, k);
        end else begin
          grant_s = grant_s;
        end
      end
    end
  end

  // One-hot acknowledge for the selected producer.
  always_comb begin
    if (grant_s) begin
      ack_s = N'(1) << win_s;
    end else begin
      ack_s = {N{1'b0}};
    end
  end

  // Occupancy update: issued write adds one, an observed read removes one,
  // never dropping below zero.
  always_comb begin
    level_d = level_q;
    if (grant_s && !(rd_obs_s && (level_q != LW'(0)))) begin
      level_d = level_q + LW'(1);
    end else if (!grant_s && rd_obs_s && (level_q != LW'(0))) begin
      level_d = level_q - LW'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Occupancy, full flag and sticky overflow error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= {LW{1'b0}};
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH - 1));
      err_q   <= err_q | bus.fifo_overflow;
    end
  end

  // Arbitration state machine with registered FIFO write strobe and data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= {PW{1'b0}};
      rr_q    <= {PW{1'b0}};
      beat_q  <= 4'd0;
      wr_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      wr_q <= grant_s;
      if (grant_s) begin
        data_q <= bus.req_data[{win_s, 3'b000} +: 8];
      end else begin
        data_q <= data_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (grant_s) begin
            state_q <= ST_BURST;
            owner_q <= win_s;
            beat_q  <= 4'd1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (hold_s) begin
            beat_q <= beat_q + 4'd1;
            if ((beat_q + 4'd1) == 4'(BURST)) begin
              rr_q    <= next_idx(owner_q);
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_BURST;
            end
          end else begin
            rr_q <= next_idx(owner_q);
            if (grant_s) begin
              owner_q <= win_s;
              beat_q  <= 4'd1;
              state_q <= ST_BURST;
            end else begin
              beat_q  <= 4'd0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          beat_q  <= 4'd0;
        end
      endcase
    end
  end

  assign bus.ack           = ack_s;
  assign bus.fifo_yazma_cs = wr_q;
  assign bus.fifo_data     = data_q;
  assign bus.level         = level_q;
  assign bus.full          = full_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: one instance with single-beat bursts and one
// with four-beat bursts, a small FIFO occupancy model driving fifo_ready, and a
// scoreboard of expected write words checked on the cycle after each grant.
module tb_fifo_write_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N(N), .DEPTH(DEPTH)) bus1 ();
  fifo_write_arbiter_if #(.N(N), .DEPTH(DEPTH)) bus4 ();

  fifo_write_arbiter #(.N(N), .DEPTH(DEPTH), .BURST(1)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  fifo_write_arbiter #(.N(N), .DEPTH(DEPTH), .BURST(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int fcnt1    = 0;
  int fcnt4    = 0;
  bit sb_on    = 1'b1;
  logic [7:0] q1[$];
  logic [7:0] q4[$];

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tag_of(input int i);
    return 8'hA0 + 8'(i);
  endfunction

  // Check the combinational ack against producer p (-1 = none) and, on an
  // expected grant, queue that producer's tag for the next-cycle write.
  task automatic expect_ack(input int which, input string tag, input int p);
    logic [N-1:0] exp_v;
    logic [N-1:0] obs_v;
    #1;
    if (p < 0) exp_v = '0;
    else exp_v = N'(1) << p;
    obs_v = (which == 1) ? bus1.ack : bus4.ack;
    check_eq(tag, 32'(obs_v), 32'(exp_v));
    if (p >= 0) begin
      if (which == 1) q1.push_back(tag_of(p));
      else q4.push_back(tag_of(p));
    end
  endtask

  // Advance one clock: update the FIFO model and check the registered writes.
  task automatic cycle();
    logic wr1, rd1, wr4, rd4;
    wr1 = bus1.fifo_yazma_cs;
    rd1 = bus1.fifo_okuma_cs & bus1.fifo_ready;
    wr4 = bus4.fifo_yazma_cs;
    rd4 = bus4.fifo_okuma_cs & bus4.fifo_ready;
    @(posedge clk);
    #1;
    if (!rst) begin
      fcnt1 = 0;
      fcnt4 = 0;
    end else begin
      fcnt1 = fcnt1 + int'(wr1) - int'(rd1);
      fcnt4 = fcnt4 + int'(wr4) - int'(rd4);
    end
    bus1.fifo_ready = (fcnt1 > 0);
    bus4.fifo_ready = (fcnt4 > 0);
    if (sb_on) begin
      check_eq("wr1", 32'(bus1.fifo_yazma_cs), 32'(q1.size() > 0));
      if (bus1.fifo_yazma_cs && q1.size() > 0)
        check_eq("data1", 32'(bus1.fifo_data), 32'(q1.pop_front()));
      check_eq("wr4", 32'(bus4.fifo_yazma_cs), 32'(q4.size() > 0));
      if (bus4.fifo_yazma_cs && q4.size() > 0)
        check_eq("data4", 32'(bus4.fifo_data), 32'(q4.pop_front()));
    end
  endtask

  // Main stimulus sequence.
  initial begin
    bus1.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus4.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus1.req = 4'hF;  bus4.req = 4'h0;
    bus1.fifo_okuma_cs = 1'b0; bus4.fifo_okuma_cs = 1'b0;
    bus1.fifo_ready = 1'b0;    bus4.fifo_ready = 1'b0;
    bus1.fifo_overflow = 1'b0; bus4.fifo_overflow = 1'b0;

    // Reset state before any clock edge, with requests already pending.
    #2;
    check_eq("rst_ack", 32'(bus1.ack), 32'h0);
    check_eq("rst_wr", 32'(bus1.fifo_yazma_cs), 32'h0);
    check_eq("rst_data", 32'(bus1.fifo_data), 32'h0);
    check_eq("rst_level", 32'(bus1.level), 32'h0);
    check_eq("rst_full", 32'(bus1.full), 32'h0);
    check_eq("rst_err", 32'(bus1.err), 32'h0);
    @(posedge clk); #1;
    check_eq("rst_ack_edge", 32'(bus1.ack), 32'h0);
    #2; rst = 1'b1;

    // Round-robin with single-beat bursts, consumer reading every cycle.
    bus1.fifo_okuma_cs = 1'b1;
    for (int k = 0; k < 12; k++) begin
      expect_ack(1, "rr_ack", k % 4);
      cycle();
    end
    bus1.req = 4'h0;
    for (int k = 0; k < 3; k++) cycle();
    check_eq("rr_drain", 32'(bus1.level), 32'h0);

    // Four-beat bursts alternating between producers 1 and 2.
    bus4.fifo_okuma_cs = 1'b1;
    bus4.req = 4'b0110;
    for (int k = 0; k < 16; k++) begin
      expect_ack(4, "burst_ack", ((k / 4) % 2 == 0) ? 1 : 2);
      cycle();
    end
    bus4.req = 4'h0;
    for (int k = 0; k < 4; k++) cycle();
    check_eq("burst_drain", 32'(bus4.level), 32'h0);

    // Fill with no reads: exactly seven grants, then the port stays closed.
    bus4.fifo_okuma_cs = 1'b0;
    bus4.req = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      expect_ack(4, "full_ack", (k < 7) ? 0 : -1);
      cycle();
    end
    check_eq("full_level", 32'(bus4.level), 32'd7);
    check_eq("full_flag", 32'(bus4.full), 32'h1);
    bus4.fifo_okuma_cs = 1'b1;
    expect_ack(4, "full_rd_ack", -1);
    cycle();
    bus4.fifo_okuma_cs = 1'b0;
    check_eq("rd_level", 32'(bus4.level), 32'd6);
    check_eq("rd_full", 32'(bus4.full), 32'h0);
    expect_ack(4, "refill_ack", 0);
    cycle();
    check_eq("refill_level", 32'(bus4.level), 32'd7);
    check_eq("refill_full", 32'(bus4.full), 32'h1);
    expect_ack(4, "refull_ack", -1);
    cycle();
    bus4.req = 4'h0;

    // Simultaneous grant and read at level 3, then a read of an empty FIFO.
    bus4.fifo_okuma_cs = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    check_eq("sim_pre", 32'(bus4.level), 32'd3);
    bus4.req = 4'b0001;
    expect_ack(4, "sim_ack", 0);
    cycle();
    bus4.req = 4'h0;
    check_eq("sim_level", 32'(bus4.level), 32'd3);
    for (int k = 0; k < 6; k++) cycle();
    check_eq("drain0", 32'(bus4.level), 32'h0);
    cycle();
    check_eq("empty_rd", 32'(bus4.level), 32'h0);

    // Sticky overflow error.
    bus4.fifo_okuma_cs = 1'b0;
    bus4.fifo_overflow = 1'b1;
    #1;
    check_eq("err_pre", 32'(bus4.err), 32'h0);
    cycle();
    bus4.fifo_overflow = 1'b0;
    check_eq("err_set", 32'(bus4.err), 32'h1);
    cycle(); cycle();
    check_eq("err_sticky", 32'(bus4.err), 32'h1);

    // Producer 3 requests during producer 0's burst and withdraws ungranted.
    bus4.req = 4'b0001;
    expect_ack(4, "wd_a", 0);
    cycle();
    bus4.req = 4'b1001;
    expect_ack(4, "wd_b", 0);
    cycle();
    bus4.req = 4'b0001;
    expect_ack(4, "wd_c", 0);
    cycle();
    bus4.req = 4'h0;
    expect_ack(4, "wd_d", -1);
    cycle();
    check_eq("wd_level", 32'(bus4.level), 32'd3);

    // Reset in the middle of a request stream.
    bus1.req = 4'hF; bus4.req = 4'hF;
    sb_on = 1'b0;
    cycle(); cycle();
    #2; rst = 1'b0;
    #1;
    check_eq("mrst_ack1", 32'(bus1.ack), 32'h0);
    check_eq("mrst_ack4", 32'(bus4.ack), 32'h0);
    check_eq("mrst_wr4", 32'(bus4.fifo_yazma_cs), 32'h0);
    check_eq("mrst_level4", 32'(bus4.level), 32'h0);
    check_eq("mrst_err4", 32'(bus4.err), 32'h0);
    q1.delete(); q4.delete();
    fcnt1 = 0; fcnt4 = 0;
    bus1.fifo_ready = 1'b0; bus4.fifo_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("mrst_hold_ack4", 32'(bus4.ack), 32'h0);
    check_eq("mrst_hold_lvl1", 32'(bus1.level), 32'h0);
    #2; rst = 1'b1;
    sb_on = 1'b1;
    expect_ack(1, "mrst_first1", 0);
    expect_ack(4, "mrst_first4", 0);
    cycle();
    bus1.req = 4'h0; bus4.req = 4'h0;
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
